wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, SHALL be the pc_w value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, SHALL be the instr_w value loaded on reset and on flush.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 flush_m  in  1  when 1, the W register SHALL capture a bubble instead of M-stage data.
REQ-006 instr_m  in  32  M-stage instruction.
REQ-007 pc_m  in  32  M-stage PC.
REQ-008 alu_m  in  32  M-stage ALU result.
REQ-009 dm_rd_m  in  32  M-stage data-memory read word.
REQ-010 ra1_d, ra2_d  in  5 each  D-stage register-file read addresses.
REQ-011 rd1_d, rd2_d  out  32 each  D-stage read data.
REQ-012 we_w  out  1  W-stage register-write enable, for the hazard unit.
REQ-013 a3_w  out  5  W-stage destination register.
REQ-014 wd_w  out  32  W-stage write data.
REQ-015 retired  out  32  count of non-bubble instructions retired.

Function
REQ-016 Each rising edge SHALL load {instr_w, pc_w, alu_w, dm_w} from M inputs, or {NOP_INSTR, pc_m, 0, 0} when flush_m=1; there is no stall.
REQ-017 Decode of instr_w SHALL recognise addu, subu, ori, lw, sw, beq, lui, j, jal, jr and nop; any other encoding SHALL decode as nop.
REQ-018 we_w SHALL be 1 only for addu, subu, ori, lw, lui and jal.
REQ-019 a3_w SHALL be rd (bits 15:11) for addu/subu, rt (bits 20:16) for ori/lw/lui, 5'd31 for jal, and 0 otherwise.
REQ-020 wd_w SHALL be dm_w for lw, pc_w+8 (mod 2^32) for jal, and alu_w otherwise.
REQ-021 The 32x32 register file SHALL write wd_w to a3_w on the rising edge when we_w=1 and a3_w!=0.
REQ-022 Register 0 SHALL always read 0, and writes to it SHALL be discarded.
REQ-023 rd1_d/rd2_d SHALL be combinational reads. When the read address equals a3_w, we_w=1 and the address is non-zero, the read SHALL return wd_w (same-cycle write-through).
REQ-024 retired SHALL increment by 1, wrapping at 2^32, on each rising edge where instr_w != NOP_INSTR.
REQ-025 Latency: an M-stage instruction SHALL appear on the W outputs 1 cycle after capture, and its register value SHALL be architecturally visible after 2 edges.

Reset
REQ-026 On reset low, all of the following SHALL clear immediately, independent of clk:
- instr_w to NOP_INSTR
- pc_w to RESET_PC
- alu_w and dm_w to 0
- all 32 registers to 0
- retired to 0
REQ-027 Consequently, during reset we_w SHALL be 0 and a3_w, wd_w, rd1_d and rd2_d SHALL all be 0.
REQ-028 A reset asserted mid-operation SHALL discard the in-flight W instruction without writing it.
REQ-029 The first capture after reset deasserts SHALL occur on the next rising edge.

Structure
REQ-030 Opcode/funct constants (R, ADDU, SUBU, ORI, LW, SW, BEQ, LUI, J, JAL, JR, NOP) and the wd-select enum {WD_ALU, WD_DM, WD_PC8} SHALL live in the shared mips_pkg, common with the other stage controllers.
REQ-031 The register file SHALL be a separate sub-module, grf, containing the storage, the $0 rule and the write-through bypass.
REQ-032 The W register, decode and wd mux SHALL live in wb_stage.

Verification
REQ-033 Reset low mid-run -> all outputs and registers 0 without waiting for a clock edge; retired=0.
REQ-034 ori $1,$0,0x1234 at M (alu_m=0x1234) -> next cycle we_w=1, a3_w=1, wd_w=0x1234; after the following edge, rd1_d with ra1_d=1 returns 0x1234.
REQ-035 jal with pc_m=0x3008 -> a3_w=31, wd_w=0x3010; $31=0x3010 afterwards.
REQ-036 lw $2 with dm_rd_m=0xDEADBEEF and ra2_d=2 in the same W cycle -> rd2_d=0xDEADBEEF before the write edge (bypass).
REQ-037 addu $0,$1,$1 with alu_m=5 -> we_w=1, but a read of register 0 stays 0; and sw/beq/flush_m -> we_w=0, with retired unchanged for the flushed bubble.
REQ-038 retired preset to 0xFFFF_FFFF via 2^32-1 retirements, or by forcing in simulation, -> the next retirement wraps it to 0.

Source files
------------

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS pipeline stage controllers.
//
// Contents:
//   OP_*        6-bit primary opcodes (instr[31:26])
//   FN_*        6-bit R-type function codes (instr[5:0])
//   INSTR_NOP   canonical bubble encoding (sll $0,$0,0)
//   REG_ZERO    index of the hard-wired zero register
//   REG_RA      link register written by jal
//   wd_sel_t    write-data source select for the W stage
//   kind_t      decoded instruction class
//   op_of/funct_of/rt_of/rd_of  field extractors
// ---------------------------------------------------------------------------
package mips_pkg;

   // Primary opcodes
   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_ORI = 6'b001101;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_LUI = 6'b001111;
   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_JAL = 6'b000011;

   // R-type function codes
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_JR   = 6'b001000;

   // The all-zero word is sll $0,$0,0, which architecturally does nothing
   localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_RA   = 5'd31;

   // Where the W-stage write data comes from
   typedef enum logic [1:0] {
      WD_ALU,
      WD_DM,
      WD_PC8
   } wd_sel_t;

   // Instruction classes that the stage controllers care about
   typedef enum logic [3:0] {
      K_NOP,
      K_ADDU,
      K_SUBU,
      K_ORI,
      K_LW,
      K_SW,
      K_BEQ,
      K_LUI,
      K_J,
      K_JAL,
      K_JR
   } kind_t;

   function automatic logic [5:0] op_of(input logic [31:0] instr);
      return instr[31:26];
   endfunction

   function automatic logic [5:0] funct_of(input logic [31:0] instr);
      return instr[5:0];
   endfunction

   function automatic logic [4:0] rt_of(input logic [31:0] instr);
      return instr[20:16];
   endfunction

   function automatic logic [4:0] rd_of(input logic [31:0] instr);
      return instr[15:11];
   endfunction

endpackage

// File: rtl/grf.sv
// ---------------------------------------------------------------------------
// grf
// 32 x 32-bit general register file with two combinational read ports and
// one synchronous write port. Register 0 is hard-wired to zero. A read that
// targets the register being written this cycle returns the write data, so
// the D stage sees W-stage results without waiting for the write edge.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset, clears every register
//   we           write enable
//   a3           write address
//   wd           write data
//   ra1, ra2     read addresses
//   rd1, rd2     read data (combinational)
// ---------------------------------------------------------------------------
module grf
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [4:0]  a3,
   input  logic [31:0] wd,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);

   logic [31:0] regs [32];
   logic        write_ok;

   // A write to $0 is silently dropped; the same qualifier gates the bypass
   assign write_ok = we && (a3 != REG_ZERO);

   // Storage update; reset clears all registers without waiting for clk
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (write_ok) begin
         regs[a3] <= wd;
      end
   end

   // Read port 1: $0 reads zero, a matching in-flight write is forwarded
   always_comb begin
      rd1 = regs[ra1];
      if (ra1 == REG_ZERO) begin
         rd1 = '0;
      end else if (write_ok && (ra1 == a3)) begin
         rd1 = wd;
      end
   end

   // Read port 2: same rules as port 1
   always_comb begin
      rd2 = regs[ra2];
      if (ra2 == REG_ZERO) begin
         rd2 = '0;
      end else if (write_ok && (ra2 == a3)) begin
         rd2 = wd;
      end
   end

endmodule

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
// Write-back stage of the five-stage MIPS pipeline. Holds the M/W pipeline
// register, decodes the W-stage instruction into a register-write request,
// selects the write data, owns the register file and counts retirements.
//
// Parameters:
//   RESET_PC     pc_w value after reset
//   NOP_INSTR    bubble encoding loaded on reset and on flush
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   flush_m      replace the incoming M-stage instruction with a bubble
//   instr_m      M-stage instruction
//   pc_m         M-stage PC
//   alu_m        M-stage ALU result
//   dm_rd_m      M-stage data-memory read word
//   ra1_d/ra2_d  D-stage register read addresses
//   rd1_d/rd2_d  D-stage register read data (combinational)
//   we_w         W-stage register-write enable
//   a3_w         W-stage destination register
//   wd_w         W-stage write data
//   retired      count of non-bubble instructions that left W
// ---------------------------------------------------------------------------
module wb_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter logic [31:0] NOP_INSTR = INSTR_NOP
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        flush_m,
   input  logic [31:0] instr_m,
   input  logic [31:0] pc_m,
   input  logic [31:0] alu_m,
   input  logic [31:0] dm_rd_m,
   input  logic [4:0]  ra1_d,
   input  logic [4:0]  ra2_d,
   output logic [31:0] rd1_d,
   output logic [31:0] rd2_d,
   output logic        we_w,
   output logic [4:0]  a3_w,
   output logic [31:0] wd_w,
   output logic [31:0] retired
);

   logic [31:0] instr_w;
   logic [31:0] pc_w;
   logic [31:0] alu_w;
   logic [31:0] dm_w;
   logic [31:0] retired_q;
   kind_t       kind_w;
   wd_sel_t     wd_sel_w;

   // M/W pipeline register. A flushed slot keeps the M-stage PC so that
   // the bubble still carries a meaningful address, but its data is zeroed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr_w <= NOP_INSTR;
         pc_w    <= RESET_PC;
         alu_w   <= '0;
         dm_w    <= '0;
      end else if (flush_m) begin
         instr_w <= NOP_INSTR;
         pc_w    <= pc_m;
         alu_w   <= '0;
         dm_w    <= '0;
      end else begin
         instr_w <= instr_m;
         pc_w    <= pc_m;
         alu_w   <= alu_m;
         dm_w    <= dm_rd_m;
      end
   end

   // Retirement counter. Anything other than the bubble encoding counts,
   // including encodings the decoder treats as nop; it wraps naturally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         retired_q <= '0;
      end else if (instr_w != NOP_INSTR) begin
         retired_q <= retired_q + 32'd1;
      end
   end

   assign retired = retired_q;

   // Classify the W instruction. Unknown opcodes and unknown R-type
   // functions fall through to K_NOP so they can never write a register.
   always_comb begin
      kind_w = K_NOP;
      if (instr_w != NOP_INSTR) begin
         case (op_of(instr_w))
            OP_R: begin
               case (funct_of(instr_w))
                  FN_ADDU: kind_w = K_ADDU;
                  FN_SUBU: kind_w = K_SUBU;
                  FN_JR:   kind_w = K_JR;
                  default: kind_w = K_NOP;
               endcase
            end
            OP_ORI:  kind_w = K_ORI;
            OP_LW:   kind_w = K_LW;
            OP_SW:   kind_w = K_SW;
            OP_BEQ:  kind_w = K_BEQ;
            OP_LUI:  kind_w = K_LUI;
            OP_J:    kind_w = K_J;
            OP_JAL:  kind_w = K_JAL;
            default: kind_w = K_NOP;
         endcase
      end
   end

   // Register-write request derived from the instruction class. The
   // destination is forced to 0 for non-writing instructions so the
   // hazard unit never sees a stale register number.
   always_comb begin
      we_w     = 1'b0;
      a3_w     = REG_ZERO;
      wd_sel_w = WD_ALU;
      case (kind_w)
         K_ADDU, K_SUBU: begin
            we_w = 1'b1;
            a3_w = rd_of(instr_w);
         end
         K_ORI, K_LUI: begin
            we_w = 1'b1;
            a3_w = rt_of(instr_w);
         end
         K_LW: begin
            we_w     = 1'b1;
            a3_w     = rt_of(instr_w);
            wd_sel_w = WD_DM;
         end
         K_JAL: begin
            we_w     = 1'b1;
            a3_w     = REG_RA;
            wd_sel_w = WD_PC8;
         end
         default: begin
            we_w     = 1'b0;
            a3_w     = REG_ZERO;
            wd_sel_w = WD_ALU;
         end
      endcase
   end

   // Write-data mux; jal links past its delay slot, hence pc+8
   always_comb begin
      case (wd_sel_w)
         WD_DM:   wd_w = dm_w;
         WD_PC8:  wd_w = pc_w + 32'd8;
         default: wd_w = alu_w;
      endcase
   end

   grf u_grf (
      .clk   (clk),
      .reset (reset),
      .we    (we_w),
      .a3    (a3_w),
      .wd    (wd_w),
      .ra1   (ra1_d),
      .ra2   (ra2_d),
      .rd1   (rd1_d),
      .rd2   (rd2_d)
   );

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage
// Directed, table-driven bench for wb_stage. Each table row is the M-stage
// input presented for one edge together with the W-stage outputs and the
// D-stage read data expected half a cycle after that edge.
// ---------------------------------------------------------------------------
module tb_wb_stage;

   logic        clk;
   logic        reset;
   logic        flush_m;
   logic [31:0] instr_m;
   logic [31:0] pc_m;
   logic [31:0] alu_m;
   logic [31:0] dm_rd_m;
   logic [4:0]  ra1_d;
   logic [4:0]  ra2_d;
   logic [31:0] rd1_d;
   logic [31:0] rd2_d;
   logic        we_w;
   logic [4:0]  a3_w;
   logic [31:0] wd_w;
   logic [31:0] retired;

   int n_compared;
   int n_mismatched;

   typedef struct {
      logic        flush;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] alu;
      logic [31:0] dm;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic        we;
      logic [4:0]  a3;
      logic [31:0] wd;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] ret;
   } vec_t;

   localparam int NVEC = 16;
   vec_t vecs [NVEC];

   wb_stage dut (
      .clk     (clk),
      .reset   (reset),
      .flush_m (flush_m),
      .instr_m (instr_m),
      .pc_m    (pc_m),
      .alu_m   (alu_m),
      .dm_rd_m (dm_rd_m),
      .ra1_d   (ra1_d),
      .ra2_d   (ra2_d),
      .rd1_d   (rd1_d),
      .rd2_d   (rd2_d),
      .we_w    (we_w),
      .a3_w    (a3_w),
      .wd_w    (wd_w),
      .retired (retired)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one set of M-stage and D-stage inputs
   task automatic applyStimulus(input vec_t v);
      flush_m = v.flush;
      instr_m = v.instr;
      pc_m    = v.pc;
      alu_m   = v.alu;
      dm_rd_m = v.dm;
      ra1_d   = v.ra1;
      ra2_d   = v.ra2;
   endtask

   // Compare one observed value against its expectation
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic checkAll(input string tag, input vec_t v);
      checkOutput({tag, ".we"},      32'(we_w),  32'(v.we));
      checkOutput({tag, ".a3"},      32'(a3_w),  32'(v.a3));
      checkOutput({tag, ".wd"},      wd_w,       v.wd);
      checkOutput({tag, ".rd1"},     rd1_d,      v.rd1);
      checkOutput({tag, ".rd2"},     rd2_d,      v.rd2);
      checkOutput({tag, ".retired"}, retired,    v.ret);
   endtask

   function automatic vec_t mk(input logic flush, input logic [31:0] instr, input logic [31:0] pc,
                               input logic [31:0] alu, input logic [31:0] dm,
                               input logic [4:0] ra1, input logic [4:0] ra2);
      vec_t v;
      v.flush = flush; v.instr = instr; v.pc = pc; v.alu = alu; v.dm = dm;
      v.ra1 = ra1; v.ra2 = ra2;
      v.we = 1'b0; v.a3 = 5'd0; v.wd = '0; v.rd1 = '0; v.rd2 = '0; v.ret = '0;
      return v;
   endfunction

   initial begin
      vec_t v;
      n_compared   = 0;
      n_mismatched = 0;

      //         flush instr         pc            alu           dm            ra1 ra2   we a3 wd rd1 rd2 ret
      vecs[0]  = '{1'b0, 32'h34011234, 32'h00003000, 32'h00001234, 32'h0,        5'd1,  5'd0,  1'b1, 5'd1,  32'h00001234, 32'h00001234, 32'h0,        32'd0};
      vecs[1]  = '{1'b0, 32'h0C000C40, 32'h00003008, 32'h0,        32'h0,        5'd1,  5'd31, 1'b1, 5'd31, 32'h00003010, 32'h00001234, 32'h00003010, 32'd1};
      vecs[2]  = '{1'b0, 32'h8C020000, 32'h0000300C, 32'h00000100, 32'hDEADBEEF, 5'd31, 5'd2,  1'b1, 5'd2,  32'hDEADBEEF, 32'h00003010, 32'hDEADBEEF, 32'd2};
      vecs[3]  = '{1'b0, 32'h00221821, 32'h00003010, 32'hDEADD123, 32'h0,        5'd2,  5'd3,  1'b1, 5'd3,  32'hDEADD123, 32'hDEADBEEF, 32'hDEADD123, 32'd3};
      vecs[4]  = '{1'b0, 32'h00210021, 32'h00003014, 32'h00000005, 32'h0,        5'd0,  5'd3,  1'b1, 5'd0,  32'h00000005, 32'h0,        32'hDEADD123, 32'd4};
      vecs[5]  = '{1'b0, 32'hAC010004, 32'h00003018, 32'h00000004, 32'h00000055, 5'd0,  5'd1,  1'b0, 5'd0,  32'h00000004, 32'h0,        32'h00001234, 32'd5};
      vecs[6]  = '{1'b0, 32'h10210003, 32'h0000301C, 32'h00000099, 32'h0,        5'd5,  5'd4,  1'b0, 5'd0,  32'h00000099, 32'h0,        32'h0,        32'd6};
      vecs[7]  = '{1'b1, 32'h3C05ABCD, 32'h00003020, 32'h000000AA, 32'h000000BB, 5'd1,  5'd2,  1'b0, 5'd0,  32'h0,        32'h00001234, 32'hDEADBEEF, 32'd7};
      vecs[8]  = '{1'b0, 32'h3C05ABCD, 32'h00003024, 32'hABCD0000, 32'h0,        5'd5,  5'd5,  1'b1, 5'd5,  32'hABCD0000, 32'hABCD0000, 32'hABCD0000, 32'd7};
      vecs[9]  = '{1'b0, 32'h00412023, 32'h00003028, 32'hDEADACBB, 32'h0,        5'd5,  5'd4,  1'b1, 5'd4,  32'hDEADACBB, 32'hABCD0000, 32'hDEADACBB, 32'd8};
      vecs[10] = '{1'b0, 32'hFC1F1234, 32'h0000302C, 32'h00000077, 32'h00000066, 5'd4,  5'd31, 1'b0, 5'd0,  32'h00000077, 32'hDEADACBB, 32'h00003010, 32'd9};
      vecs[11] = '{1'b0, 32'h08000010, 32'h00003030, 32'h00000011, 32'h0,        5'd0,  5'd0,  1'b0, 5'd0,  32'h00000011, 32'h0,        32'h0,        32'd10};
      vecs[12] = '{1'b0, 32'h03E00008, 32'h00003034, 32'h00000022, 32'h0,        5'd0,  5'd0,  1'b0, 5'd0,  32'h00000022, 32'h0,        32'h0,        32'd11};
      vecs[13] = '{1'b0, 32'h00000000, 32'h00003038, 32'h00000033, 32'h0,        5'd0,  5'd0,  1'b0, 5'd0,  32'h00000033, 32'h0,        32'h0,        32'd12};
      vecs[14] = '{1'b0, 32'h0C000C40, 32'hFFFFFFFC, 32'h0,        32'h0,        5'd31, 5'd0,  1'b1, 5'd31, 32'h00000004, 32'h00000004, 32'h0,        32'd12};
      vecs[15] = '{1'b0, 32'h34060006, 32'h00003040, 32'h00000006, 32'h0,        5'd31, 5'd6,  1'b1, 5'd6,  32'h00000006, 32'h00000004, 32'h00000006, 32'd13};

      // Hold reset across an edge with live M-stage inputs; nothing may leak out
      reset = 1'b0;
      applyStimulus(vecs[0]);
      ra1_d = 5'd1;
      ra2_d = 5'd31;
      repeat (2) @(negedge clk);
      checkOutput("rst.we",      32'(we_w), 32'd0);
      checkOutput("rst.a3",      32'(a3_w), 32'd0);
      checkOutput("rst.wd",      wd_w,      32'd0);
      checkOutput("rst.rd1",     rd1_d,     32'd0);
      checkOutput("rst.rd2",     rd2_d,     32'd0);
      checkOutput("rst.retired", retired,   32'd0);

      // Release reset; the first table row is captured on the very next edge
      reset = 1'b1;
      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i]);
         @(negedge clk);
         checkAll($sformatf("v%0d", i), vecs[i]);
      end

      // Counter wrap: preset to all ones while ori $6 sits in W
      force dut.retired_q = 32'hFFFF_FFFF;
      #1;
      release dut.retired_q;
      v = mk(1'b0, 32'h0, 32'h00003044, 32'h0, 32'h0, 5'd6, 5'd0);
      applyStimulus(v);
      @(negedge clk);
      checkOutput("wrap.retired", retired, 32'd0);
      checkOutput("wrap.rd1",     rd1_d,   32'h00000006);
      @(negedge clk);
      checkOutput("wrap.hold",    retired, 32'd0);

      // Put ori $7 in W, then reset asynchronously before its write edge
      v = mk(1'b0, 32'h34070777, 32'h00003048, 32'h00000777, 32'h0, 5'd7, 5'd6);
      applyStimulus(v);
      @(negedge clk);
      checkOutput("pre.we",  32'(we_w), 32'd1);
      checkOutput("pre.rd1", rd1_d,     32'h00000777);
      checkOutput("pre.rd2", rd2_d,     32'h00000006);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async.we",      32'(we_w), 32'd0);
      checkOutput("async.a3",      32'(a3_w), 32'd0);
      checkOutput("async.wd",      wd_w,      32'd0);
      checkOutput("async.rd1",     rd1_d,     32'd0);
      checkOutput("async.rd2",     rd2_d,     32'd0);
      checkOutput("async.retired", retired,   32'd0);
      v = mk(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd7, 5'd6);
      applyStimulus(v);
      @(negedge clk);

      // Deassert and present jal at once; it must be in W after one edge,
      // and the discarded ori $7 must never have reached the register file
      reset = 1'b1;
      v = mk(1'b0, 32'h0C000C40, 32'h00003008, 32'h0, 32'h0, 5'd7, 5'd31);
      applyStimulus(v);
      @(negedge clk);
      checkOutput("post.we",      32'(we_w), 32'd1);
      checkOutput("post.a3",      32'(a3_w), 32'd31);
      checkOutput("post.wd",      wd_w,      32'h00003010);
      checkOutput("post.rd1",     rd1_d,     32'd0);
      checkOutput("post.rd2",     rd2_d,     32'h00003010);
      checkOutput("post.retired", retired,   32'd0);
      v = mk(1'b0, 32'h0, 32'h0000300C, 32'h0, 32'h0, 5'd31, 5'd6);
      applyStimulus(v);
      @(negedge clk);
      checkOutput("post2.rd1",     rd1_d,   32'h00003010);
      checkOutput("post2.rd2",     rd2_d,   32'd0);
      checkOutput("post2.retired", retired, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
